// File: rtl/diff_demo_pkg.sv
// Shared constants and types for the diff-demo datapath, including the
// write-back scheduler state encoding and descriptor queue depth.
package diff_demo_pkg;

  localparam int FM_GUARD_GEN_PSUM_BUF_DEPTH = 64;
  localparam int WBS_DESC_DEPTH              = 4;

  typedef enum logic [2:0] {
    WBS_IDLE,
    WBS_LOAD,
    WBS_ISSUE,
    WBS_WAIT,
    WBS_DONE
  } wbs_state_t;

endpackage

// File: rtl/wb_scheduler_if.sv
// Control bundle between the tile sequencer, the write-back scheduler and
// write-back. The scheduler side uses the slave modport.
interface wb_scheduler_if
  import diff_demo_pkg::*;
#(
  parameter int ADDR_W = $clog2(FM_GUARD_GEN_PSUM_BUF_DEPTH),
  parameter int TILE_W = 16
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [TILE_W-1:0] cfg_tile_num;
  logic              cfg_is_diff;

  logic              desc_valid;
  logic              desc_ready;
  logic              desc_bank;
  logic [ADDR_W-1:0] desc_stop_addr;

  logic              wb_ctrl_valid;
  logic              wb_ctrl_ready;
  logic              wb_ctrl_finish;
  logic [ADDR_W-1:0] wb_stop_addr;
  logic              wb_is_diff;
  logic              wb_bank_sel;

  logic [1:0]        bank_release;
  logic              layer_done;
  logic [TILE_W-1:0] tile_cnt;
  logic              err;

  modport slave (
    input  cfg_valid, cfg_tile_num, cfg_is_diff,
    input  desc_valid, desc_bank, desc_stop_addr,
    input  wb_ctrl_ready, wb_ctrl_finish,
    output cfg_ready, desc_ready,
    output wb_ctrl_valid, wb_stop_addr, wb_is_diff, wb_bank_sel,
    output bank_release, layer_done, tile_cnt, err
  );

  modport master (
    output cfg_valid, cfg_tile_num, cfg_is_diff,
    output desc_valid, desc_bank, desc_stop_addr,
    output wb_ctrl_ready, wb_ctrl_finish,
    input  cfg_ready, desc_ready,
    input  wb_ctrl_valid, wb_stop_addr, wb_is_diff, wb_bank_sel,
    input  bank_release, layer_done, tile_cnt, err
  );
endinterface

// File: rtl/wbs_desc_fifo.sv
// Descriptor queue: synchronous FIFO with first-word-fall-through head,
// full/empty flags and a single-cycle flush.
module wbs_desc_fifo #(
  parameter int W     = 7,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  input  logic         flush,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [AW:0]             wr_ptr_q, wr_ptr_d;
  logic [AW:0]             rd_ptr_q, rd_ptr_d;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push && !full) begin
        mem_d[wr_ptr_q[AW-1:0]] = wdata;
        wr_ptr_d                = wr_ptr_q + 1'b1;
      end
      if (pop && !empty) rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
endmodule

// File: rtl/wb_scheduler.sv
// Layer-level sequencer for write-back: queues per-tile psum bank descriptors
// and issues them one at a time, releasing banks and flagging layer completion.
module wb_scheduler
  import diff_demo_pkg::*;
#(
  parameter int ADDR_W     = $clog2(FM_GUARD_GEN_PSUM_BUF_DEPTH),
  parameter int DESC_DEPTH = WBS_DESC_DEPTH,
  parameter int TILE_W     = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  wb_scheduler_if.slave  bus
);
  wbs_state_t        state_q, state_d;
  logic [TILE_W-1:0] tile_num_q, tile_num_d;
  logic [TILE_W-1:0] tile_cnt_q, tile_cnt_d;
  logic [TILE_W-1:0] tile_cnt_inc;
  logic              is_diff_q, is_diff_d;
  logic              err_q, err_d;
  logic              cur_bank_q, cur_bank_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [1:0]        release_q, release_d;

  logic              fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [ADDR_W:0]   head;
  logic              head_bank;
  logic [ADDR_W-1:0] head_addr;

  logic              cfg_ready, wb_valid, wb_bank_sel, layer_done;
  logic [ADDR_W-1:0] wb_stop_addr;

  assign fifo_push    = bus.desc_valid && bus.desc_ready;
  assign head_bank    = head[ADDR_W];
  assign head_addr    = head[ADDR_W-1:0];
  assign tile_cnt_inc = tile_cnt_q + 1'b1;

  wbs_desc_fifo #(.W(ADDR_W + 1), .DEPTH(DESC_DEPTH)) u_desc_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata ({bus.desc_bank, bus.desc_stop_addr}),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    tile_num_d   = tile_num_q;
    tile_cnt_d   = tile_cnt_q;
    is_diff_d    = is_diff_q;
    err_d        = err_q;
    cur_bank_d   = cur_bank_q;
    cur_addr_d   = cur_addr_q;
    release_d    = '0;
    fifo_pop     = 1'b0;
    fifo_flush   = 1'b0;
    cfg_ready    = 1'b0;
    wb_valid     = 1'b0;
    wb_stop_addr = '0;
    wb_bank_sel  = 1'b0;
    layer_done   = 1'b0;
    unique case (state_q)
      WBS_IDLE: begin
        cfg_ready = 1'b1;
        if (bus.cfg_valid) begin
          tile_num_d = bus.cfg_tile_num;
          is_diff_d  = bus.cfg_is_diff;
          tile_cnt_d = '0;
          err_d      = 1'b0;
          state_d    = (bus.cfg_tile_num == '0) ? WBS_DONE : WBS_LOAD;
        end
      end
      WBS_LOAD: if (!fifo_empty) state_d = WBS_ISSUE;
      WBS_ISSUE: begin
        wb_valid     = 1'b1;
        wb_stop_addr = head_addr;
        wb_bank_sel  = head_bank;
        if (bus.wb_ctrl_ready) begin
          fifo_pop   = 1'b1;
          cur_bank_d = head_bank;
          cur_addr_d = head_addr;
          state_d    = WBS_WAIT;
        end
      end
      WBS_WAIT: begin
        wb_stop_addr = cur_addr_q;
        wb_bank_sel  = cur_bank_q;
        if (bus.wb_ctrl_finish) begin
          tile_cnt_d            = tile_cnt_inc;
          release_d[cur_bank_q] = 1'b1;
          state_d = (tile_cnt_inc == tile_num_q) ? WBS_DONE : WBS_LOAD;
        end
      end
      WBS_DONE: begin
        // Leftover descriptors belong to no tile of this layer.
        layer_done = 1'b1;
        fifo_flush = 1'b1;
        if (!fifo_empty) err_d = 1'b1;
        state_d = WBS_IDLE;
      end
      default: state_d = WBS_IDLE;
    endcase
    if (bus.wb_ctrl_finish && state_q != WBS_WAIT) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= WBS_IDLE;
      tile_num_q <= '0;
      tile_cnt_q <= '0;
      is_diff_q  <= 1'b0;
      err_q      <= 1'b0;
      cur_bank_q <= 1'b0;
      cur_addr_q <= '0;
      release_q  <= '0;
    end else begin
      state_q    <= state_d;
      tile_num_q <= tile_num_d;
      tile_cnt_q <= tile_cnt_d;
      is_diff_q  <= is_diff_d;
      err_q      <= err_d;
      cur_bank_q <= cur_bank_d;
      cur_addr_q <= cur_addr_d;
      release_q  <= release_d;
    end
  end

  assign bus.cfg_ready     = cfg_ready;
  assign bus.desc_ready    = (state_q != WBS_IDLE) && !fifo_full;
  assign bus.wb_ctrl_valid = wb_valid;
  assign bus.wb_stop_addr  = wb_stop_addr;
  assign bus.wb_is_diff    = is_diff_q;
  assign bus.wb_bank_sel   = wb_bank_sel;
  assign bus.bank_release  = release_q;
  assign bus.layer_done    = layer_done;
  assign bus.tile_cnt      = tile_cnt_q;
  assign bus.err           = err_q;
endmodule

// File: tb/tb_wb_scheduler.sv
// Scoreboard bench for wb_scheduler: descriptors are queued as expected
// commands on push and compared when write-back accepts them.
module tb_wb_scheduler;
  import diff_demo_pkg::*;
  localparam int ADDR_W = $clog2(FM_GUARD_GEN_PSUM_BUF_DEPTH);
  localparam int TILE_W = 16;
  localparam logic [31:0] RST_V = 32'h4000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_scheduler_if #(.ADDR_W(ADDR_W), .TILE_W(TILE_W)) bif ();

  wb_scheduler #(.ADDR_W(ADDR_W), .DESC_DEPTH(4), .TILE_W(TILE_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Write-back model: finishes 5 cycles after accept, ready back the cycle after finish.
  logic wb_en = 1'b0, wb_busy = 1'b0, fin_model = 1'b0, fin_force = 1'b0, fin_prev;
  logic m_acc, m_rs;
  int   wb_cnt = 0;
  assign bif.wb_ctrl_ready  = wb_en && !wb_busy;
  assign bif.wb_ctrl_finish = fin_model | fin_force;

  initial forever begin
    @(negedge clk);
    m_acc = bif.wb_ctrl_valid && bif.wb_ctrl_ready;
    m_rs  = rst_n;
    @(posedge clk); #1;
    fin_prev  = fin_model;
    fin_model = 1'b0;
    if (!m_rs) begin
      wb_busy = 1'b0; wb_cnt = 0;
    end else if (m_acc) begin
      wb_busy = 1'b1; wb_cnt = 4;
    end else if (fin_prev) begin
      wb_busy = 1'b0;
    end else if (wb_busy) begin
      wb_cnt--;
      if (wb_cnt == 0) fin_model = 1'b1;
    end
  end

  // Scoreboard monitor
  logic [ADDR_W:0] exp_q[$];
  logic [1:0]      rel_q[$];
  logic [ADDR_W:0] e;
  int cyc_n = 0, last_fin = 0, pop_cnt = 0, done_cnt = 0;
  bit chk_done_lat = 1'b1;

  always @(posedge clk) cyc_n++;

  always @(negedge clk) if (rst_n) begin
    if (bif.desc_valid && bif.desc_ready) exp_q.push_back({bif.desc_bank, bif.desc_stop_addr});
    if (bif.wb_ctrl_valid && bif.wb_ctrl_ready) begin
      pop_cnt++;
      if (exp_q.size() == 0) chk("cmd_extra", 32'(exp_q.size()), 1);
      else begin
        e = exp_q.pop_front();
        chk("cmd", {bif.wb_bank_sel, bif.wb_stop_addr}, e);
        rel_q.push_back(e[ADDR_W] ? 2'b10 : 2'b01);
      end
    end
    if (bif.bank_release != 2'b00) begin
      if (rel_q.size() == 0) chk("rel_extra", 32'(rel_q.size()), 1);
      else chk("bank_release", bif.bank_release, rel_q.pop_front());
    end
    if (bif.wb_ctrl_finish) last_fin = cyc_n;
    if (bif.layer_done) begin
      done_cnt++;
      if (chk_done_lat) chk("done_lat", cyc_n - last_fin, 1);
    end
  end

  function automatic logic [31:0] outv();
    return 32'({bif.cfg_ready, bif.desc_ready, bif.wb_ctrl_valid, bif.wb_stop_addr,
                bif.wb_is_diff, bif.wb_bank_sel, bif.bank_release, bif.layer_done,
                bif.tile_cnt, bif.err});
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_cfg(input int n, input bit d);
    bif.cfg_valid    = 1'b1;
    bif.cfg_tile_num = TILE_W'(n);
    bif.cfg_is_diff  = d;
    @(negedge clk);
    chk("cfg_ready", bif.cfg_ready, 1);
    tick();
    bif.cfg_valid = 1'b0;
  endtask

  task automatic push_desc(input bit b, input logic [ADDR_W-1:0] a);
    int k;
    k = 0;
    bif.desc_valid     = 1'b1;
    bif.desc_bank      = b;
    bif.desc_stop_addr = a;
    @(negedge clk);
    while (!bif.desc_ready && k < 100) begin
      tick(); @(negedge clk); k++;
    end
    if (k >= 100) chk("push_timeout", bif.desc_ready, 1);
    tick();
    bif.desc_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int k;
    k = 0;
    @(negedge clk);
    while (!bif.layer_done && k < bound) begin
      @(negedge clk); k++;
    end
    chk("layer_done_seen", bif.layer_done, 1);
  endtask

  bit ok;
  int p0;

  initial begin
    bif.cfg_valid = 1'b0; bif.cfg_tile_num = '0; bif.cfg_is_diff = 1'b0;
    bif.desc_valid = 1'b0; bif.desc_bank = 1'b0; bif.desc_stop_addr = '0;
    repeat (2) tick();
    @(negedge clk);
    chk("reset_vals", outv(), RST_V);
    tick();
    rst_n = 1'b1;

    // Basic layer
    wb_en = 1'b1;
    do_cfg(3, 1'b0);
    push_desc(1'b0, 6'h3F);
    push_desc(1'b1, 6'h20);
    push_desc(1'b0, 6'h3F);
    wait_done(200);
    chk("basic_tile_cnt", bif.tile_cnt, 3);
    tick();
    chk("basic_exp_empty", 32'(exp_q.size()), 0);
    chk("basic_rel_empty", 32'(rel_q.size()), 0);

    // Zero tiles
    chk_done_lat = 1'b0;
    do_cfg(0, 1'b0);
    @(negedge clk);
    chk("zero_done", bif.layer_done, 1);
    chk("zero_no_valid", bif.wb_ctrl_valid, 0);
    chk("zero_busy", bif.cfg_ready, 0);
    tick();
    @(negedge clk);
    chk("zero_cfg_ready", bif.cfg_ready, 1);
    chk("zero_done_low", bif.layer_done, 0);
    tick();
    chk_done_lat = 1'b1;

    // Backpressure: write-back holds ready low
    wb_en = 1'b0;
    do_cfg(6, 1'b0);
    for (int i = 0; i < 4; i++) push_desc(i[0], ADDR_W'(6'h10 + i));
    @(negedge clk);
    chk("bp_full", bif.desc_ready, 0);
    tick();
    p0 = pop_cnt;
    bif.desc_valid = 1'b1; bif.desc_bank = 1'b0; bif.desc_stop_addr = 6'h14;
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bif.desc_ready) ok = 1'b0;
      tick();
    end
    chk("bp_hold", ok, 1);
    wb_en = 1'b1;
    begin
      int k;
      k = 0;
      @(negedge clk);
      while (!bif.desc_ready && k < 50) begin tick(); @(negedge clk); k++; end
    end
    chk("bp_5th_ready", bif.desc_ready, 1);
    chk("bp_pop_first", pop_cnt - p0, 1);
    tick();
    bif.desc_valid = 1'b0;
    push_desc(1'b1, 6'h15);
    wait_done(400);
    chk("bp_tile_cnt", bif.tile_cnt, 6);
    tick();

    // Starved FIFO
    do_cfg(2, 1'b1);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bif.wb_ctrl_valid || !bif.desc_ready) ok = 1'b0;
      tick();
    end
    chk("starve_load", ok, 1);
    @(negedge clk);
    chk("is_diff", bif.wb_is_diff, 1);
    tick();
    push_desc(1'b1, 6'h2A);
    @(negedge clk);
    chk("starve_m1", bif.wb_ctrl_valid, 0);
    tick();
    @(negedge clk);
    chk("starve_m2", bif.wb_ctrl_valid, 1);
    tick();
    push_desc(1'b0, 6'h05);
    wait_done(200);
    chk("starve_tile_cnt", bif.tile_cnt, 2);
    tick();

    // Protocol error: finish while in LOAD
    do_cfg(1, 1'b0);
    fin_force = 1'b1;
    tick();
    fin_force = 1'b0;
    @(negedge clk);
    chk("err_set", bif.err, 1);
    chk("err_tile_cnt", bif.tile_cnt, 0);
    repeat (3) tick();
    @(negedge clk);
    chk("err_sticky", bif.err, 1);
    tick();
    push_desc(1'b0, 6'h11);
    wait_done(200);
    chk("err_at_done", bif.err, 1);
    tick();
    chk_done_lat = 1'b0;
    do_cfg(0, 1'b0);
    @(negedge clk);
    chk("err_cleared", bif.err, 0);
    tick();
    chk_done_lat = 1'b1;

    // Reset mid-layer in WAIT with two descriptors queued
    do_cfg(4, 1'b0);
    p0 = pop_cnt;
    push_desc(1'b1, 6'h01);
    push_desc(1'b0, 6'h02);
    push_desc(1'b1, 6'h03);
    chk("rst_in_wait", pop_cnt - p0, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    rel_q.delete();
    @(negedge clk);
    chk("rst_mid_vals", outv(), RST_V);
    tick();
    do_cfg(1, 1'b0);
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bif.wb_ctrl_valid) ok = 1'b0;
      tick();
    end
    chk("rst_fifo_empty", ok, 1);
    push_desc(1'b0, 6'h3E);
    wait_done(200);
    tick();

    chk("final_exp_empty", 32'(exp_q.size()), 0);
    chk("final_rel_empty", 32'(rel_q.size()), 0);
    chk("done_cnt", done_cnt, 7);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
